// File: rtl/keypad_entry_debouncer.sv
// Keypad front end for microwave time entry: synchronise, debounce, priority-encode, one load strobe per press.
// Optional build macro KEYPAD_MULTIKEY_REJECT_EN rejects presses with more than one key down.
module keypad_entry_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [9:0] keypad,
    input  logic       enable,
    output logic [3:0] d,
    output logic       loadn,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_LOAD     = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Lowest set bit wins; an all-zero vector encodes as digit 0.
    function automatic logic [3:0] lowest_index(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            idx = v[i] ? 4'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    logic [9:0]       sync1_r;
    logic [9:0]       ks_r;
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [9:0]       kv_r;
    logic [9:0]       kv_nxt_s;
    logic [3:0]       d_r;
    logic [3:0]       d_nxt_s;
    logic             loadn_r;
    logic             loadn_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             accept_s;
    logic             multi_s;

    // Two-flop synchroniser for the asynchronous keypad lines.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            sync1_r <= 10'd0;
            ks_r    <= 10'd0;
        end else begin
            sync1_r <= keypad;
            ks_r    <= sync1_r;
        end
    end

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    // Only a single key may start a press; a vector with several keys is a multi-press.
    always_comb begin
        accept_s = is_onehot(ks_r);
        multi_s  = (ks_r != 10'd0) && !is_onehot(ks_r);
    end
`else
    // Any non-zero vector may start a press; the lowest digit is loaded.
    always_comb begin
        accept_s = (ks_r != 10'd0);
        multi_s  = 1'b0;
    end
`endif

    // Next-state logic: a press must hold its exact vector for the whole debounce window.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        kv_nxt_s    = kv_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !enable) begin
                    kv_nxt_s    = ks_r;
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_DEBOUNCE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (ks_r != kv_r) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = multi_s ? ST_WAIT_REL : ST_IDLE;
                end else if (enable) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_WAIT_REL;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_LOAD;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_LOAD: begin
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (ks_r != 10'd0) begin
                    cnt_nxt_s = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                kv_nxt_s    = 10'd0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so they line up with the LOAD cycle itself.
    always_comb begin
        loadn_nxt_s = (state_nxt_s != ST_LOAD);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        if (state_nxt_s == ST_LOAD) begin
            d_nxt_s = lowest_index(kv_r);
        end else begin
            d_nxt_s = d_r;
        end
    end

    // State, counter, captured vector and registered outputs.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            kv_r    <= 10'd0;
            d_r     <= 4'd0;
            loadn_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            kv_r    <= kv_nxt_s;
            d_r     <= d_nxt_s;
            loadn_r <= loadn_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign d     = d_r;
    assign loadn = loadn_r;
    assign busy  = busy_r;

    keypad_entry_debouncer_checker u_checker (
        .clock  (clock),
        .clearn (clearn),
        .loadn  (loadn_r),
        .busy   (busy_r)
    );

endmodule

// Protocol properties of the load strobe.
module keypad_entry_debouncer_checker (
    input logic clock,
    input logic clearn,
    input logic loadn,
    input logic busy
);

    a_single_cycle_strobe: assert property (@(posedge clock) disable iff (!clearn) !loadn |=> loadn);
    a_strobe_implies_busy: assert property (@(posedge clock) disable iff (!clearn) !loadn |-> busy);

endmodule

// File: tb/tb_keypad_entry_debouncer.sv
// Randomised scoreboard bench for keypad_entry_debouncer with a press-level reference model.
`timescale 1ns/1ps
module tb_keypad_entry_debouncer;

    localparam int D = 4;

    logic       clock  = 1'b0;
    logic       clearn = 1'b0;
    logic [9:0] keypad = 10'd0;
    logic       enable = 1'b0;
    logic [3:0] d;
    logic       loadn;
    logic       busy;

    keypad_entry_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clock  (clock),
        .clearn (clearn),
        .keypad (keypad),
        .enable (enable),
        .d      (d),
        .loadn  (loadn),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] digit;
        int         edge_no;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   pulse_cnt = 0;
    int   last_pulse_edge = 0;
    logic prev_loadn = 1'b1;

    // Reference model: run lengths of the synchronised key vector decide each press.
    logic [9:0] h1 = 10'd0, h2 = 10'd0, m_ks = 10'd0, cand = 10'd0;
    int         cand_age = -1;
    bit         waiting = 1'b0;
    int         zero_run = 0;
    bit         load_step = 1'b0;
    bit         start_ok;
    logic [3:0] d_exp = 4'd0;
    bit         busy_exp = 1'b0;

    function automatic logic [3:0] lowest_digit(input logic [9:0] v);
        for (int i = 0; i < 10; i++) if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    always @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            h1 = 10'd0; h2 = 10'd0; cand = 10'd0; cand_age = -1; waiting = 1'b0;
            zero_run = 0; load_step = 1'b0; d_exp = 4'd0; busy_exp = 1'b0;
            exp_q.delete();
        end else begin
            edge_n++;
            m_ks = h2; h2 = h1; h1 = keypad;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
            start_ok = ($countones(m_ks) == 1);
`else
            start_ok = (m_ks != 10'd0);
`endif
            if (load_step) begin
                load_step = 1'b0; waiting = 1'b1; zero_run = 0;
            end else if (waiting) begin
                if (m_ks != 10'd0) zero_run = 0;
                else begin
                    zero_run++;
                    if (zero_run == D) waiting = 1'b0;
                end
            end else if (cand_age >= 0) begin
                if (m_ks != cand) begin
                    cand_age = -1;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
                    if ($countones(m_ks) > 1) begin waiting = 1'b1; zero_run = 0; end
`endif
                end else if (enable) begin
                    cand_age = -1; waiting = 1'b1; zero_run = 0;
                end else begin
                    cand_age++;
                    if (cand_age == D) begin
                        cand_age = -1; load_step = 1'b1;
                        d_exp = lowest_digit(cand);
                        exp_q.push_back('{d_exp, edge_n});
                    end
                end
            end else if (start_ok && !enable) begin
                cand = m_ks; cand_age = 0;
            end
            busy_exp = load_step || waiting || (cand_age >= 0);
        end
    end

    // Monitor: compares every cycle and pops the scoreboard on each strobe.
    always @(negedge clock) begin
        if (clearn) begin
            checks++;
            if (d !== d_exp) begin errors++; $display("FAIL d_value: got %0d expected %0d at edge %0d", d, d_exp, edge_n); end
            checks++;
            if (busy !== busy_exp) begin errors++; $display("FAIL busy: got %0b expected %0b at edge %0d", busy, busy_exp, edge_n); end
            if (loadn === 1'b0) begin
                pulse_cnt++;
                last_pulse_edge = edge_n;
                checks++;
                if (!prev_loadn) begin errors++; $display("FAIL strobe_width: loadn low two cycles at edge %0d", edge_n); end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_pulse: got d=%0d at edge %0d expected none", d, edge_n);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.digit !== d || mon_e.edge_no != edge_n) begin
                        errors++;
                        $display("FAIL pulse: got d=%0d edge %0d expected d=%0d edge %0d", d, edge_n, mon_e.digit, mon_e.edge_no);
                    end
                end
            end else if (loadn !== 1'b1) begin
                checks++; errors++; $display("FAIL loadn_x: got %b expected 0/1", loadn);
            end else if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_n) begin
                checks++; errors++;
                $display("FAIL missed_pulse: got none expected d=%0d at edge %0d", exp_q[0].digit, exp_q[0].edge_no);
                void'(exp_q.pop_front());
            end
            prev_loadn = loadn;
        end else begin
            prev_loadn = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [9:0] v, input int hold);
        keypad = v;
        cyc(hold);
    endtask

    task automatic release_keys(input int n);
        keypad = 10'd0;
        cyc(n);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin errors++; $display("FAIL %s: got %0d expected %0d", name, got, want); end
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, "_d"}, int'(d), 0);
        check_val({name, "_loadn"}, int'(loadn), 1);
        check_val({name, "_busy"}, int'(busy), 0);
    endtask

    int base;
    int e1;
    logic [9:0] rv;

    initial begin
        cyc(3);
        #1 check_reset_outputs("reset");
        #1 clearn = 1'b1;
        cyc(2);

        // Single press of key 5: latency and strobe count.
        base = pulse_cnt; e1 = edge_n + 1;
        press(10'b0000100000, 20);
        release_keys(12);
        check_val("t1_pulses", pulse_cnt - base, 1);
        check_val("t1_latency", last_pulse_edge - e1, D + 2);
        check_val("t1_d", int'(d), 5);

        // Bouncing key 2, then a stable hold.
        base = pulse_cnt;
        for (int i = 0; i < 3; i++) begin
            press(10'b0000000100, 2);
            release_keys(2);
        end
        check_val("t2_bounce_pulses", pulse_cnt - base, 0);
        press(10'b0000000100, 20);
        release_keys(12);
        check_val("t2_pulses", pulse_cnt - base, 1);
        check_val("t2_d", int'(d), 2);

        // Long hold plus full release, then a release that is too short.
        base = pulse_cnt;
        press(10'b1000000000, 1000);
        release_keys(10);
        press(10'b1000000000, 20);
        release_keys(12);
        check_val("t3_two_presses", pulse_cnt - base, 2);
        base = pulse_cnt;
        press(10'b1000000000, 20);
        release_keys(2);
        press(10'b1000000000, 20);
        release_keys(12);
        check_val("t3_short_release", pulse_cnt - base, 1);

        // Magnetron on blocks entry; a press caught by enable needs a full release.
        base = pulse_cnt;
        enable = 1'b1;
        press(10'b0000010000, 20);
        release_keys(10);
        enable = 1'b0;
        cyc(5);
        keypad = 10'b0000010000;
        cyc(3);
        enable = 1'b1;
        cyc(10);
        enable = 1'b0;
        cyc(10);
        release_keys(12);
        check_val("t4_blocked", pulse_cnt - base, 0);
        press(10'b0000010000, 20);
        release_keys(12);
        check_val("t4_repress", pulse_cnt - base, 1);
        check_val("t4_d", int'(d), 4);

        // Two keys at once.
        base = pulse_cnt;
        press(10'b0010001000, 20);
        release_keys(12);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        check_val("t5_pulses", pulse_cnt - base, 0);
        check_val("t5_d", int'(d), 4);
`else
        check_val("t5_pulses", pulse_cnt - base, 1);
        check_val("t5_d", int'(d), 3);
`endif

        // Reset in the middle of debouncing key 7.
        base = pulse_cnt;
        keypad = 10'b0010000000;
        cyc(4);
        #2 clearn = 1'b0;
        #1 check_reset_outputs("t6_reset");
        @(negedge clock);
        #2 clearn = 1'b1;
        cyc(20);
        release_keys(12);
        check_val("t6_pulses", pulse_cnt - base, 1);
        check_val("t6_d", int'(d), 7);

        // Randomised keys, holds, gaps and enable toggles.
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: rv = 10'd1 << $urandom_range(0, 9);
                6, 7:             rv = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
                default:          rv = 10'd0;
            endcase
            if ($urandom_range(0, 7) == 0) enable = ~enable;
            press(rv, $urandom_range(1, 25));
            release_keys($urandom_range(0, 10));
        end
        enable = 1'b0;
        release_keys(20);
        check_val("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
